// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, handshake FSM
// encoding and the op classification helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op_v);
        is_multicycle = (op_v == OP_MULU) || (op_v == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle. done is a one-cycle pulse alongside the final iteration's value.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    logic                 busy_r;
    logic                 is_div_r;
    logic [SHW-1:0]       cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [2*WIDTH-1:0]   acc_nxt_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_trial_s;

    // One iteration of either algorithm; the carry/borrow bit is kept in the extra MSB
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opnd_r};
        if (is_div_r) begin
            if (div_trial_s[WIDTH] == 1'b0) begin
                acc_nxt_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    assign done = busy_r && (cnt_r == CNT_LAST);
    assign lo   = acc_nxt_s[WIDTH-1:0];
    assign hi   = acc_nxt_s[2*WIDTH-1:WIDTH];

    // Operand latch, accumulator and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            is_div_r <= 1'b0;
            cnt_r    <= {SHW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r   <= 1'b1;
            is_div_r <= is_div;
            cnt_r    <= {SHW{1'b0}};
            acc_r    <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            opnd_r   <= is_div ? b : a;
        end else if (busy_r) begin
            busy_r   <= !done;
            cnt_r    <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
            acc_r    <= acc_nxt_s;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready on both sides. Single-cycle ops
// complete in one clock; MULU/DIVU iterate in alu_muldiv_iter.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             dz,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] result_r, hi_r;
    logic             zero_r, ovf_r, dz_r, err_r;
    logic             accept_s, mc_start_s, iter_done_s;
    logic [WIDTH-1:0] iter_lo_s, iter_hi_s;
    logic [WIDTH-1:0] sc_res_s, sc_hi_s;
    logic             sc_ovf_s, sc_dz_s, sc_err_s;
    logic [WIDTH-1:0] sum_s, diff_s, bneg_s;
    logic [SHW-1:0]   shamt_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign result    = result_r;
    assign hi        = hi_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;
    assign dz        = dz_r;
    assign err       = err_r;

    assign accept_s   = in_valid && in_ready;
    // Divide by zero never enters the iterator; it retires like a single-cycle op
    assign mc_start_s = accept_s && is_multicycle(op) &&
                        !((op == OP_DIVU) && (b == {WIDTH{1'b0}}));
    assign sum_s      = a + b;
    assign bneg_s     = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    assign diff_s     = a + bneg_s;
    assign shamt_s    = b[SHW-1:0];

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mc_start_s),
        .is_div (op == OP_DIVU),
        .a      (a),
        .b      (b),
        .done   (iter_done_s),
        .lo     (iter_lo_s),
        .hi     (iter_hi_s)
    );

    // Single-cycle results and flags
    always_comb begin
        sc_res_s = {WIDTH{1'b0}};
        sc_hi_s  = {WIDTH{1'b0}};
        sc_ovf_s = 1'b0;
        sc_dz_s  = 1'b0;
        sc_err_s = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res_s = sum_s;
                sc_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s = diff_s;
                sc_ovf_s = (a[WIDTH-1] == bneg_s[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res_s = a & b;
            OP_OR:   sc_res_s = a | b;
            OP_XOR:  sc_res_s = a ^ b;
            OP_NOR:  sc_res_s = ~(a | b);
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  sc_res_s = a << shamt_s;
            OP_SRL:  sc_res_s = a >> shamt_s;
            OP_SRA:  sc_res_s = $unsigned($signed(a) >>> shamt_s);
            OP_MULU: sc_res_s = {WIDTH{1'b0}};
            OP_DIVU: begin
                if (b == {WIDTH{1'b0}}) begin
                    sc_res_s = {WIDTH{1'b1}};
                    sc_hi_s  = a;
                    sc_dz_s  = 1'b1;
                end else begin
                    sc_res_s = {WIDTH{1'b0}};
                end
            end
            default: sc_err_s = 1'b1;
        endcase
    end

    // Handshake FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mc_start_s) begin
                    state_nxt_s = ST_BUSY;
                end else if (accept_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (iter_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Result and flag registers: loaded on retire, cleared when an iteration starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            dz_r     <= 1'b0;
            err_r    <= 1'b0;
        end else if (mc_start_s) begin
            result_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            dz_r     <= 1'b0;
            err_r    <= 1'b0;
        end else if (accept_s) begin
            result_r <= sc_res_s;
            hi_r     <= sc_hi_s;
            zero_r   <= (sc_res_s == {WIDTH{1'b0}});
            ovf_r    <= sc_ovf_s;
            dz_r     <= sc_dz_s;
            err_r    <= sc_err_s;
        end else if ((state_r == ST_BUSY) && iter_done_s) begin
            result_r <= iter_lo_s;
            hi_r     <= iter_hi_s;
            zero_r   <= (iter_lo_s == {WIDTH{1'b0}});
            ovf_r    <= 1'b0;
            dz_r     <= 1'b0;
            err_r    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): a plain-arithmetic reference model
// plus literal expectations for the headline vectors.
module tb_alu_mc;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        dz;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        ovf;
  logic        dz;
  logic        err;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_r;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .ovf       (ovf),
    .dz        (dz),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  // Reference: true signed arithmetic in 64 bits, native / and %, wide product
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = 32'h0; e.hi = 32'h0; e.ovf = 1'b0; e.dz = 1'b0; e.err = 1'b0; e.lat = 1;
    case (o)
      4'd0: begin s = sx + sy; e.res = x + y; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sx - sy; e.res = x - y; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = x ^ y;
      4'd5: e.res = ~(x | y);
      4'd6: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd7: e.res = (x < y) ? 32'd1 : 32'd0;
      4'd8: e.res = x << y[4:0];
      4'd9: e.res = x >> y[4:0];
      4'd10: e.res = $unsigned($signed(x) >>> y[4:0]);
      4'd11: begin p = {32'h0, x} * {32'h0, y}; e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33; end
      4'd12: begin
        if (y == 32'h0) begin e.res = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; e.lat = 33; end
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Whenever a result is presented, every output field must match the model
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("cmp_result", result, exp_r.res);
      chk("cmp_hi", hi, exp_r.hi);
      chk("cmp_flags", {zero, ovf, dz, err}, {exp_r.zero, exp_r.ovf, exp_r.dz, exp_r.err});
      chk("cmp_in_ready_done", in_ready, 1'b0);
    end
  end

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, input bit use_lit,
                        input logic [31:0] lit_res, input logic [31:0] lit_hi);
    int n;
    exp_r = model(o, x, y);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) chk("busy_in_ready", in_ready, 1'b0);
    end while (!out_valid && n < 200);
    chk("latency", n, exp_r.lat);
    if (use_lit) begin
      chk("lit_result", result, lit_res);
      chk("lit_hi", hi, lit_hi);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = OP_SUB; a = 32'd50; b = 32'd9;
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("retire_out_valid", out_valid, 1'b0);
    chk("retire_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = 32'h0; b = 32'h0;
    exp_r = model(4'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_outputs", {result, hi, zero, ovf, dz, err, out_valid}, 71'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    run_op(OP_ADD,  32'h7FFF_FFFF, 32'd1, 0, 1'b1, 32'h8000_0000, 32'h0);
    run_op(OP_SUB,  32'd1, 32'd1, 0, 1'b1, 32'h0, 32'h0);
    run_op(OP_SLT,  32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'd1, 32'h0);
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'd0, 32'h0);
    run_op(OP_SRA,  32'h8000_0000, 32'd4, 0, 1'b1, 32'hF800_0000, 32'h0);
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'd2, 0, 1'b1, 32'hFFFF_FFFE, 32'd1);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b1, 32'd14, 32'd2);
    run_op(OP_DIVU, 32'd7, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, 32'd7);
    run_op(OP_ADD,  32'd3, 32'd4, 5, 1'b1, 32'd7, 32'h0);
    run_op(OP_SUB,  32'h8000_0000, 32'd1, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_SUB,  32'd5, 32'd9, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_NOR,  32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_SLL,  32'h0000_00F1, 32'hFFFF_FF23, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_SRL,  32'h8765_4321, 32'd31, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b0, 32'h0, 32'h0);
    run_op(OP_DIVU, 32'd5, 32'd9, 0, 1'b0, 32'h0, 32'h0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0003, 0, 1'b0, 32'h0, 32'h0);
    run_op(4'd15,   32'd3, 32'd3, 0, 1'b1, 32'h0, 32'h0);

    // Reset in the middle of a MULU
    exp_r = model(OP_MULU, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    op = OP_MULU; a = 32'hFFFF_FFFF; b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("busy_rst_outputs", {result, hi, zero, ovf, dz, err, out_valid}, 71'h0);
    chk("busy_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("busy_rst_discarded", out_valid, 1'b0);

    // Reset while a result is being held
    exp_r = model(OP_ADD, 32'd3, 32'd4);
    @(negedge clk);
    op = OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_before_rst", {out_valid, result}, {1'b1, 32'd7});
    #2;
    rst_n = 1'b0;
    #1;
    chk("done_rst_outputs", {result, hi, zero, ovf, dz, err, out_valid}, 71'h0);
    chk("done_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd14, 32'hAAAA_5555, 32'd1, 0, 1'b1, 32'h0, 32'h0);
    chk("illegal_err_held", err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
